// File: rtl/mfs_pkg.sv
// rtl/mfs_pkg.sv - shared types and constants for the factor search; MFS_SKIP_TRIVIAL_EN selects the factor sweep start
package mfs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Product width: a full A_W x B_W product never exceeds A_W+B_W bits.
  function automatic int p_w(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

`ifdef MFS_SKIP_TRIVIAL_EN
  // Factors 0 and 1 give only trivial factorisations, so the sweep starts at 2.
  localparam int FACTOR_LO = 2;
`else
  localparam int FACTOR_LO = 0;
`endif

endpackage

// File: rtl/mfs_shift_add_mul.sv
// rtl/mfs_shift_add_mul.sv - B_W-cycle shift-add multiplier, LSB of b first
module mfs_shift_add_mul
  import mfs_pkg::*;
#(
  parameter int A_W = 5,
  parameter int B_W = 3,
  parameter int P_W = p_w(A_W, B_W)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  output logic [P_W-1:0] product_o,
  output logic           last_o
);

  localparam int CNT_W = $clog2(B_W + 1);

  logic [P_W-1:0]   acc_q, acc_d;
  logic [P_W-1:0]   mcand_q, mcand_d;
  logic [B_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load clears the accumulator; each step adds the shifted multiplicand if the current b bit is set.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = P_W'(a_i);
      mplier_d = b_i;
      cnt_d    = '0;
    end else if (step_i) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign product_o = acc_q;
  assign last_o    = (cnt_q == CNT_W'(B_W - 1));

endmodule

// File: rtl/multiplier_factor_search.sv
// rtl/multiplier_factor_search.sv - sequential factor search over all (a,b); MFS_SKIP_TRIVIAL_EN excludes factors 0 and 1
module multiplier_factor_search
  import mfs_pkg::*;
#(
  parameter int A_W = 5,
  parameter int B_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [A_W+B_W-1:0]   target,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic [A_W-1:0]       a_out,
  output logic [B_W-1:0]       b_out
);

  localparam int P_W = p_w(A_W, B_W);
  localparam logic [A_W-1:0] A_LO = A_W'(FACTOR_LO);
  localparam logic [B_W-1:0] B_LO = B_W'(FACTOR_LO);
  localparam logic [A_W-1:0] A_HI = '1;
  localparam logic [B_W-1:0] B_HI = '1;

  state_e         state_q, state_d;
  logic [P_W-1:0] target_q, target_d;
  logic [A_W-1:0] a_q, a_d, a_out_q, a_out_d;
  logic [B_W-1:0] b_q, b_d, b_out_q, b_out_d;
  logic           found_q, found_d;
  logic           mul_load;
  logic           mul_last;
  logic [P_W-1:0] product;

  mfs_shift_add_mul #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (mul_load),
    .step_i    (state_q == MUL),
    .a_i       (a_d),
    .b_i       (b_d),
    .product_o (product),
    .last_o    (mul_last)
  );

  // Next-state, sweep counters and result registers; the multiplier loads whatever pair is entered next.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    a_d      = a_q;
    b_d      = b_q;
    found_d  = found_q;
    a_out_d  = a_out_q;
    b_out_d  = b_out_q;
    mul_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          target_d = target;
          a_d      = A_LO;
          b_d      = B_LO;
          found_d  = 1'b0;
          a_out_d  = '0;
          b_out_d  = '0;
          mul_load = 1'b1;
          state_d  = MUL;
        end
      end
      MUL: begin
        if (mul_last) state_d = CMP;
      end
      CMP: begin
        if (product == target_q) begin
          found_d = 1'b1;
          a_out_d = a_q;
          b_out_d = b_q;
          state_d = DONE;
        end else if (a_q == A_HI && b_q == B_HI) begin
          found_d = 1'b0;
          state_d = DONE;
        end else begin
          if (b_q == B_HI) begin
            b_d = B_LO;
            a_d = a_q + A_W'(1);
          end else begin
            b_d = b_q + B_W'(1);
          end
          mul_load = 1'b1;
          state_d  = MUL;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides everything once a search is under way.
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      found_d  = 1'b0;
      a_out_d  = '0;
      b_out_d  = '0;
      mul_load = 1'b0;
    end
  end

  // Control and result state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      found_q  <= 1'b0;
      a_out_q  <= '0;
      b_out_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      a_q      <= a_d;
      b_q      <= b_d;
      found_q  <= found_d;
      a_out_q  <= a_out_d;
      b_out_q  <= b_out_d;
    end
  end

  assign busy  = (state_q == MUL) || (state_q == CMP);
  assign done  = (state_q == DONE);
  assign found = found_q;
  assign a_out = a_out_q;
  assign b_out = b_out_q;

endmodule

// File: tb/tb_multiplier_factor_search.sv
// tb/tb_multiplier_factor_search.sv - directed self-checking bench for multiplier_factor_search
module tb_multiplier_factor_search;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] target = 8'd0;
  logic       busy, done, found;
  logic [4:0] a_out;
  logic [2:0] b_out;

  int checks = 0;
  int errors = 0;
  int cyc;
  int saw;

`ifdef MFS_SKIP_TRIVIAL_EN
  localparam int SWEEP   = 30 * 6 * 4 + 1;
  localparam int CYC35   = 24 * 4 + 1;
  localparam int T7_F    = 0;
  localparam int T7_A    = 0;
  localparam int T7_B    = 0;
  localparam int T0_F    = 0;
  localparam int T0_CYC  = 30 * 6 * 4 + 1;
`else
  localparam int SWEEP   = 256 * 4 + 1;
  localparam int CYC35   = 48 * 4 + 1;
  localparam int T7_F    = 1;
  localparam int T7_A    = 1;
  localparam int T7_B    = 7;
  localparam int T0_F    = 1;
  localparam int T0_CYC  = 5;
`endif

  multiplier_factor_search #(.A_W(5), .B_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .target (target),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .a_out  (a_out),
    .b_out  (b_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [7:0] tgt, output int n);
    @(negedge clk);
    target = tgt;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
  endtask

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_a", a_out, 0);
    check("rst_b", b_out, 0);
    rst_n = 1'b1;

    // 1: UNSAT full sweep
    run(8'd37, cyc);
    check("t37_cycles", cyc, SWEEP);
    check("t37_found", found, 0);
    check("t37_a", a_out, 0);
    check("t37_b", b_out, 0);
    check("t37_busy", busy, 0);
    @(negedge clk);
    check("t37_done_pulse", done, 0);

    // 2: first hit 5*7
    run(8'd35, cyc);
    check("t35_cycles", cyc, CYC35);
    check("t35_busy", busy, 0);
    check("t35_found", found, 1);
    check("t35_a", a_out, 5);
    check("t35_b", b_out, 7);
    @(negedge clk);
    check("t35_hold_a", a_out, 5);
    check("t35_hold_found", found, 1);

    // 3: prime target
    run(8'd7, cyc);
    check("t7_found", found, T7_F);
    check("t7_a", a_out, T7_A);
    check("t7_b", b_out, T7_B);

    // 4: zero target
    run(8'd0, cyc);
    check("t0_cycles", cyc, T0_CYC);
    check("t0_found", found, T0_F);
    check("t0_a", a_out, 0);
    check("t0_b", b_out, 0);

    // 5: abort mid-search then restart
    @(negedge clk);
    target = 8'd217;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("ab_busy_before", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    check("ab_found", found, 0);
    check("ab_a", a_out, 0);
    check("ab_b", b_out, 0);
    saw = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw++;
    end
    check("ab_quiet", saw, 0);
    run(8'd217, cyc);
    check("t217_cycles", cyc, SWEEP);
    check("t217_found", found, 1);
    check("t217_a", a_out, 31);
    check("t217_b", b_out, 7);

    // 6a: reset mid-search
    @(negedge clk);
    target = 8'd37;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_found", found, 0);
    check("mr_a", a_out, 0);
    check("mr_b", b_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw++;
    end
    check("mr_quiet", saw, 0);

    // 6b: start and target change while busy are ignored
    @(negedge clk);
    target = 8'd35;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    repeat (4) begin
      @(negedge clk);
      cyc++;
    end
    start  = 1'b1;
    target = 8'd7;
    @(negedge clk);
    cyc++;
    start  = 1'b0;
    target = 8'd0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("sb_cycles", cyc, CYC35);
    check("sb_a", a_out, 5);
    check("sb_b", b_out, 7);

    // 6c: start and abort together in IDLE, abort wins
    @(negedge clk);
    target = 8'd35;
    start  = 1'b1;
    abort  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", busy, 0);
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw++;
    end
    check("sa_quiet", saw, 0);
    check("sa_hold_a", a_out, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
